// File: rtl/adder_pkg.sv
// Shared definitions for the adder library and its clocked consumers.
package adder_pkg;

  typedef enum logic {ST_ACC, ST_OUT} facc_state_t;

  // Counter width able to hold the values 0..len.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/frame_accumulator_if.sv
// Operand stream in, frame result out, both valid/ready.
interface frame_accumulator_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// W-bit ripple carry adder built from a chain of full adders.
module ripple_carry_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[W];

endmodule

// File: rtl/frame_accumulator.sv
// Sums fixed-length frames of LEN operands and hands out the total with a sticky overflow flag.
module frame_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 6,
  parameter int unsigned LEN   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  frame_accumulator_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  facc_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sovf_q, sovf_d;

  logic [ACC_W-1:0] next_c;
  logic             cout_c;

  ripple_carry_adder #(.W(ACC_W)) u_adder (
    .a      (acc_q),
    .b      (ACC_W'(bus.in_data)),
    .cin    (1'b0),
    .sum_c  (next_c),
    .cout_c (cout_c)
  );

  // Next-state and datapath update; clr overrides everything except the held result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sovf_d  = sovf_q;

    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.in_valid) begin
            if (cnt_q == CNT_LAST) begin
              sum_d   = next_c;
              sovf_d  = ovf_q | cout_c;
              acc_d   = '0;
              ovf_d   = 1'b0;
              cnt_d   = '0;
              state_d = ST_OUT;
            end else begin
              acc_d = next_c;
              ovf_d = ovf_q | cout_c;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sovf_q  <= sovf_d;
    end
  end

  // Handshake flags come straight from the state register.
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = sovf_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed checks of frame_accumulator at ACC_W=6 and ACC_W=5 driven in lockstep.
module tb_frame_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_accumulator_if #(.N(4), .ACC_W(6)) bus6 ();
  frame_accumulator_if #(.N(4), .ACC_W(5)) bus5 ();

  frame_accumulator #(.N(4), .ACC_W(6), .LEN(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus6)
  );

  frame_accumulator #(.N(4), .ACC_W(5), .LEN(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic r);
    bus6.in_valid = v;  bus5.in_valid = v;
    bus6.in_data  = d;  bus5.in_data  = d;
    bus6.out_ready = r; bus5.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    bus6.in_valid = 1'b1; bus5.in_valid = 1'b1;
    bus6.in_data  = d;    bus5.in_data  = d;
    tick();
    bus6.in_valid = 1'b0; bus5.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] sum, input logic ovf);
    chk({tag, ".valid"}, 32'(bus6.out_valid), 32'd1);
    chk({tag, ".ready"}, 32'(bus6.in_ready), 32'd0);
    chk({tag, ".sum"},   32'(bus6.out_sum), 32'(sum));
    chk({tag, ".ovf"},   32'(bus6.out_ovf), 32'(ovf));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus6.out_valid), 32'd0);
    chk({tag, ".ready"}, 32'(bus6.in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 4'd0, 1'b1);
    #2;
    chk_idle("rst");
    chk("rst.sum", 32'(bus6.out_sum), 32'd0);
    chk("rst.ovf", 32'(bus6.out_ovf), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // basic frame
    send(4'd1); send(4'd2); send(4'd3);
    chk_idle("basic.mid");
    send(4'd4);
    chk_out("basic", 6'd10, 1'b0);
    tick();
    chk_idle("basic.done");
    chk("basic.hold", 32'(bus6.out_sum), 32'd10);

    // max operands, both widths
    send(4'd15); send(4'd15); send(4'd15); send(4'd15);
    chk_out("max6", 6'd60, 1'b0);
    chk("max5.sum", 32'(bus5.out_sum), 32'd28);
    chk("max5.ovf", 32'(bus5.out_ovf), 32'd1);
    tick();

    // backpressure with ignored operands
    bus6.out_ready = 1'b0; bus5.out_ready = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_out("bp.first", 6'd4, 1'b0);
    drive(1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("bp.stall", 6'd4, 1'b0);
    end
    drive(1'b0, 4'd0, 1'b1);
    tick();
    chk_idle("bp.release");
    send(4'd5); send(4'd5); send(4'd5); send(4'd5);
    chk_out("bp.next", 6'd20, 1'b0);
    tick();

    // clear coincident with an operand
    send(4'd7); send(4'd7);
    clr = 1'b1;
    send(4'd9);
    clr = 1'b0;
    chk_idle("clr.after");
    chk("clr.hold", 32'(bus6.out_sum), 32'd20);
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_out("clr.frame", 6'd4, 1'b0);
    tick();

    // clear drops a pending result
    bus6.out_ready = 1'b0; bus5.out_ready = 1'b0;
    send(4'd3); send(4'd3); send(4'd3); send(4'd3);
    chk_out("clrout.pend", 6'd12, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_idle("clrout.drop");
    chk("clrout.hold", 32'(bus6.out_sum), 32'd12);
    bus6.out_ready = 1'b1; bus5.out_ready = 1'b1;

    // bubbles between operands
    for (int i = 0; i < 3; i++) begin
      send(4'd2);
      tick();
      chk_idle("bubble.gap");
    end
    send(4'd2);
    chk_out("bubble", 6'd8, 1'b0);
    tick();

    // reset mid-frame
    send(4'd1); send(4'd1); send(4'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rstmid");
    chk("rstmid.sum", 32'(bus6.out_sum), 32'd0);
    #1 rst_n = 1'b1;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_out("rstmid.frame", 6'd4, 1'b0);

    // reset while a result is pending
    bus6.out_ready = 1'b0; bus5.out_ready = 1'b0;
    tick();
    chk_out("rstout.pend", 6'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("rstout");
    chk("rstout.sum", 32'(bus6.out_sum), 32'd0);
    chk("rstout.ovf5", 32'(bus5.out_ovf), 32'd0);
    #1 rst_n = 1'b1;
    bus6.out_ready = 1'b1; bus5.out_ready = 1'b1;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_out("rstout.frame", 6'd4, 1'b0);
    tick();
    chk_idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
